cu_cta_dispatch: RTL and testbench

//  Kernel-launch sequencer downstream of the CU CSR slave (clk domain). On a kernel-start

---
 rtl/cu_pkg.sv | 28 ++
 rtl/cu_cta_idgen.sv | 56 +++++
 rtl/cu_cta_dispatch.sv | 175 +++++++++++++++++
 tb/tb_cu_cta_dispatch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types for the CU kernel-launch sequencer: dispatch FSM states,
// the CTA descriptor layout and the error-flag bit positions.
package cu_pkg;

    localparam int CU_NCTA_W = 32;
    localparam int CU_PC_W   = 32;
    localparam int CU_NTID_W = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } disp_state_e;

    typedef struct packed {
        logic [CU_NCTA_W-1:0] id_x;
        logic [CU_NCTA_W-1:0] id_y;
        logic [CU_NCTA_W-1:0] id_z;
        logic [CU_NTID_W-1:0] ntid;
        logic [CU_PC_W-1:0]   pc;
    } cta_desc_t;

    localparam int ERR_START_BUSY = 0;
    localparam int ERR_SPUR_DONE  = 1;

endpackage

// File: rtl/cu_cta_idgen.sv
// Three-dimensional CTA id counter: x fastest, then y, then z.
// Limits are grid sizes; compares use limit-1 so an all-ones limit cannot overflow.
module cu_cta_idgen #(
    parameter int NCTA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [NCTA_W-1:0] lim_x_i,
    input  logic [NCTA_W-1:0] lim_y_i,
    input  logic [NCTA_W-1:0] lim_z_i,
    output logic [NCTA_W-1:0] id_x_o,
    output logic [NCTA_W-1:0] id_y_o,
    output logic [NCTA_W-1:0] id_z_o,
    output logic              last_o
);

    logic [NCTA_W-1:0] x_q, y_q, z_q;
    logic              at_x, at_y, at_z;

    assign at_x   = (x_q == lim_x_i - NCTA_W'(1));
    assign at_y   = (y_q == lim_y_i - NCTA_W'(1));
    assign at_z   = (z_q == lim_z_i - NCTA_W'(1));
    assign last_o = at_x & at_y & at_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else if (clear_i || load_i) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else if (step_i) begin
            if (!at_x) begin
                x_q <= x_q + NCTA_W'(1);
            end else begin
                x_q <= '0;
                if (!at_y) begin
                    y_q <= y_q + NCTA_W'(1);
                end else begin
                    y_q <= '0;
                    z_q <= at_z ? '0 : z_q + NCTA_W'(1);
                end
            end
        end
    end

    assign id_x_o = x_q;
    assign id_y_o = y_q;
    assign id_z_o = z_q;

endmodule

// File: rtl/cu_cta_dispatch.sv
// Kernel-launch sequencer: snapshots the launch config, walks every CTA id and
// hands one descriptor per valid/ready handshake to the warp scheduler.
module cu_cta_dispatch
    import cu_pkg::*;
#(
    parameter int NCTA_W       = 32,
    parameter int PC_W         = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic [11:0]       cfg_ntid_x,
    input  logic [11:0]       cfg_ntid_y,
    input  logic [5:0]        cfg_ntid_z,
    input  logic [NCTA_W-1:0] cfg_nctaid_x,
    input  logic [NCTA_W-1:0] cfg_nctaid_y,
    input  logic [NCTA_W-1:0] cfg_nctaid_z,
    input  logic [PC_W-1:0]   cfg_init_pc,
    output logic              cta_valid,
    input  logic              cta_ready,
    output logic [NCTA_W-1:0] cta_id_x,
    output logic [NCTA_W-1:0] cta_id_y,
    output logic [NCTA_W-1:0] cta_id_z,
    output logic [29:0]       cta_ntid,
    output logic [PC_W-1:0]   cta_pc,
    input  logic              cta_done,
    output logic              busy,
    output logic              kernel_done,
    output logic [31:0]       issued_cnt,
    output logic [1:0]        err_sticky
);

    localparam int             IW     = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0]  MAX_IF = IW'(MAX_INFLIGHT);

    // Handshake: a descriptor transfers on any rising edge where cta_valid and
    // cta_ready are both high; once raised, cta_valid and the payload hold
    // until that transfer happens (valid never drops while waiting on ready).

    disp_state_e       state_q;
    logic              valid_q, busy_q, kdone_q;
    logic [29:0]       ntid_q;
    logic [PC_W-1:0]   pc_q;
    logic [NCTA_W-1:0] nx_q, ny_q, nz_q;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic [31:0]       issued_q;
    logic [1:0]        err_q;

    logic hs, spurious, id_last, zero_grid;

    assign hs        = valid_q & cta_ready;
    assign spurious  = cta_done & ~hs & (inflight_q == '0);
    assign zero_grid = (nx_q == '0) | (ny_q == '0) | (nz_q == '0);

    // Retire and issue in the same cycle cancel out; a retire with nothing
    // outstanding is dropped and only flagged.
    always_comb begin
        inflight_d = inflight_q;
        case ({hs, cta_done})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    cu_cta_idgen #(.NCTA_W(NCTA_W)) u_idgen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .load_i  (state_q == ST_LOAD),
        .step_i  (hs),
        .lim_x_i (nx_q),
        .lim_y_i (ny_q),
        .lim_z_i (nz_q),
        .id_x_o  (cta_id_x),
        .id_y_o  (cta_id_y),
        .id_z_o  (cta_id_z),
        .last_o  (id_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            kdone_q    <= 1'b0;
            ntid_q     <= '0;
            pc_q       <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            nz_q       <= '0;
            inflight_q <= '0;
            issued_q   <= '0;
            err_q      <= '0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            kdone_q    <= 1'b0;
            ntid_q     <= '0;
            pc_q       <= '0;
            nx_q       <= '0;
            ny_q       <= '0;
            nz_q       <= '0;
            inflight_q <= '0;
            issued_q   <= '0;
            err_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            kdone_q    <= 1'b0;
            if (spurious) err_q[ERR_SPUR_DONE] <= 1'b1;
            if (start && state_q != ST_IDLE) err_q[ERR_START_BUSY] <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ntid_q   <= {cfg_ntid_z, cfg_ntid_y, cfg_ntid_x};
                        pc_q     <= cfg_init_pc;
                        nx_q     <= cfg_nctaid_x;
                        ny_q     <= cfg_nctaid_y;
                        nz_q     <= cfg_nctaid_z;
                        issued_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (zero_grid) begin
                        busy_q  <= 1'b0;
                        kdone_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        valid_q <= (inflight_d < MAX_IF);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (hs) issued_q <= issued_q + 32'd1;
                    if (hs && id_last) begin
                        valid_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        valid_q <= (inflight_d < MAX_IF);
                    end
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        busy_q  <= 1'b0;
                        kdone_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cta_valid   = valid_q;
    assign cta_ntid    = ntid_q;
    assign cta_pc      = pc_q;
    assign busy        = busy_q;
    assign kernel_done = kdone_q;
    assign issued_cnt  = issued_q;
    assign err_sticky  = err_q;

endmodule

// File: tb/tb_cu_cta_dispatch.sv
// Directed bench for cu_cta_dispatch: one task per scenario, inline checks,
// scheduler side driven from the falling edge.
module tb_cu_cta_dispatch;

    logic        clk = 1'b0;
    logic        rst, clear, start;
    logic [11:0] cfg_ntid_x, cfg_ntid_y;
    logic [5:0]  cfg_ntid_z;
    logic [31:0] cfg_nctaid_x, cfg_nctaid_y, cfg_nctaid_z, cfg_init_pc;
    logic        cta_valid, cta_ready, cta_done;
    logic [31:0] cta_id_x, cta_id_y, cta_id_z, cta_pc;
    logic [29:0] cta_ntid;
    logic        busy, kernel_done;
    logic [31:0] issued_cnt;
    logic [1:0]  err_sticky;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_if  = 0;

    always #5 clk = ~clk;

    cu_cta_dispatch #(.NCTA_W(32), .PC_W(32), .MAX_INFLIGHT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .start        (start),
        .cfg_ntid_x   (cfg_ntid_x),
        .cfg_ntid_y   (cfg_ntid_y),
        .cfg_ntid_z   (cfg_ntid_z),
        .cfg_nctaid_x (cfg_nctaid_x),
        .cfg_nctaid_y (cfg_nctaid_y),
        .cfg_nctaid_z (cfg_nctaid_z),
        .cfg_init_pc  (cfg_init_pc),
        .cta_valid    (cta_valid),
        .cta_ready    (cta_ready),
        .cta_id_x     (cta_id_x),
        .cta_id_y     (cta_id_y),
        .cta_id_z     (cta_id_z),
        .cta_ntid     (cta_ntid),
        .cta_pc       (cta_pc),
        .cta_done     (cta_done),
        .busy         (busy),
        .kernel_done  (kernel_done),
        .issued_cnt   (issued_cnt),
        .err_sticky   (err_sticky)
    );

    // Pulse start with a config, then scramble cfg_* to prove only the snapshot matters.
    task automatic do_start(input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] nz,
                            input logic [11:0] tx, input logic [11:0] ty, input logic [5:0] tz,
                            input logic [31:0] pc);
        @(negedge clk);
        cfg_nctaid_x = nx; cfg_nctaid_y = ny; cfg_nctaid_z = nz;
        cfg_ntid_x = tx; cfg_ntid_y = ty; cfg_ntid_z = tz;
        cfg_init_pc = pc;
        start = 1'b1; cta_done = 1'b0; model_if = 0;
        @(negedge clk);
        start = 1'b0;
        cfg_nctaid_x = nx + 32'd7; cfg_nctaid_y = ny + 32'd3; cfg_nctaid_z = nz + 32'd5;
        cfg_ntid_x = ~tx; cfg_init_pc = ~pc;
    endtask

    // One scheduler cycle: sample at the falling edge, drive ready/done for the next rising edge.
    task automatic sched_cycle(input logic rdy, input logic do_done, output logic hs);
        logic dn;
        @(negedge clk);
        hs = cta_valid & rdy;
        dn = do_done && (model_if > 0);
        cta_ready = rdy;
        cta_done  = dn;
        model_if  = model_if + int'(hs) - int'(dn);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; start = 1'b0; cta_ready = 1'b0; cta_done = 1'b0;
        cfg_ntid_x = '0; cfg_ntid_y = '0; cfg_ntid_z = '0;
        cfg_nctaid_x = '0; cfg_nctaid_y = '0; cfg_nctaid_z = '0; cfg_init_pc = '0;
        repeat (3) @(negedge clk);
        total_cnt++; if (cta_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cta_valid); else pass_cnt++;
        total_cnt++; if ({busy, kernel_done} !== 2'b00) $display("FAIL reset_status: got %b want 00", {busy, kernel_done}); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd0) $display("FAIL reset_issued: got %0d want 0", issued_cnt); else pass_cnt++;
        total_cnt++; if (err_sticky !== 2'b00) $display("FAIL reset_err: got %b want 00", err_sticky); else pass_cnt++;
        total_cnt++; if ({cta_id_x, cta_id_y, cta_id_z, cta_ntid, cta_pc} !== '0)
            $display("FAIL reset_payload: got %h want 0", {cta_id_x, cta_id_y, cta_id_z, cta_ntid, cta_pc}); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if ({cta_valid, busy} !== 2'b00) $display("FAIL idle_after_reset: got %b want 00", {cta_valid, busy}); else pass_cnt++;
    endtask

    task automatic test_grid_2x2x1();
        logic [95:0] exp_ids [4];
        logic hs;
        int n = 0, kd = 0, first_c = -1;
        exp_ids[0] = {32'd0, 32'd0, 32'd0};
        exp_ids[1] = {32'd1, 32'd0, 32'd0};
        exp_ids[2] = {32'd0, 32'd1, 32'd0};
        exp_ids[3] = {32'd1, 32'd1, 32'd0};
        do_start(32'd2, 32'd2, 32'd1, 12'd32, 12'd4, 6'd1, 32'h1000_0040);
        total_cnt++; if ({busy, cta_valid} !== 2'b10) $display("FAIL g221_load: got busy/valid %b want 10", {busy, cta_valid}); else pass_cnt++;
        for (int c = 0; c < 40 && kd == 0; c++) begin
            sched_cycle(1'b1, 1'b1, hs);
            if (kernel_done) kd++;
            if (hs) begin
                if (first_c < 0) first_c = c;
                total_cnt++;
                if (n >= 4) $display("FAIL g221_extra: got desc %0d want only 4", n);
                else if ({cta_id_x, cta_id_y, cta_id_z} !== exp_ids[n])
                    $display("FAIL g221_id%0d: got %h want %h", n, {cta_id_x, cta_id_y, cta_id_z}, exp_ids[n]);
                else pass_cnt++;
                if (n == 0) begin
                    total_cnt++; if (cta_ntid !== {6'd1, 12'd4, 12'd32}) $display("FAIL g221_ntid: got %h want %h", cta_ntid, {6'd1, 12'd4, 12'd32}); else pass_cnt++;
                    total_cnt++; if (cta_pc !== 32'h1000_0040) $display("FAIL g221_pc: got %h want 10000040", cta_pc); else pass_cnt++;
                end
                n++;
            end
        end
        total_cnt++; if (first_c !== 0) $display("FAIL g221_first_valid: got cycle %0d want 0", first_c); else pass_cnt++;
        total_cnt++; if (n !== 4) $display("FAIL g221_count: got %0d want 4", n); else pass_cnt++;
        total_cnt++; if (kd !== 1) $display("FAIL g221_kdone: got %0d want 1", kd); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd4) $display("FAIL g221_issued: got %0d want 4", issued_cnt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL g221_busy: got %b want 0", busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (kernel_done !== 1'b0) $display("FAIL g221_kdone_pulse: got %b want 0", kernel_done); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd4) $display("FAIL g221_issued_hold: got %0d want 4", issued_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic hs;
        int n = 0, kd = 0, stall_n = 0;
        do_start(32'd3, 32'd1, 32'd1, 12'd64, 12'd1, 6'd1, 32'h2000_0000);
        for (int c = 0; c < 60 && kd == 0; c++) begin
            sched_cycle(!(n == 1 && stall_n < 5), 1'b1, hs);
            if (kernel_done) kd++;
            if (cta_valid && !hs) begin
                stall_n++;
                total_cnt++; if ({cta_id_x, cta_id_y, cta_id_z} !== {32'd1, 32'd0, 32'd0})
                    $display("FAIL bp_hold%0d: got %h want 1,0,0", stall_n, {cta_id_x, cta_id_y, cta_id_z}); else pass_cnt++;
            end
            if (hs) begin
                total_cnt++; if ({cta_id_x, cta_id_y, cta_id_z} !== {n[31:0], 32'd0, 32'd0})
                    $display("FAIL bp_id%0d: got %h want x=%0d", n, {cta_id_x, cta_id_y, cta_id_z}, n); else pass_cnt++;
                n++;
            end
        end
        total_cnt++; if (stall_n !== 5) $display("FAIL bp_stalls: got %0d want 5", stall_n); else pass_cnt++;
        total_cnt++; if (n !== 3) $display("FAIL bp_count: got %0d want 3", n); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd3) $display("FAIL bp_issued: got %0d want 3", issued_cnt); else pass_cnt++;
        total_cnt++; if (kd !== 1) $display("FAIL bp_kdone: got %0d want 1", kd); else pass_cnt++;
    endtask

    task automatic test_inflight_limit();
        logic hs;
        int hs_n = 0, rel_n, kd = 0;
        do_start(32'd20, 32'd1, 32'd1, 12'd32, 12'd1, 6'd1, 32'h3000_0000);
        repeat (14) begin
            sched_cycle(1'b1, 1'b0, hs);
            if (hs) hs_n++;
        end
        total_cnt++; if (hs_n !== 8) $display("FAIL lim_issued_before_stall: got %0d want 8", hs_n); else pass_cnt++;
        total_cnt++; if ({cta_valid, busy} !== 2'b01) $display("FAIL lim_valid_drop: got valid/busy %b want 01", {cta_valid, busy}); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd8) $display("FAIL lim_issued_cnt: got %0d want 8", issued_cnt); else pass_cnt++;
        for (int r = 0; r < 2; r++) begin
            sched_cycle(1'b1, 1'b1, hs);
            rel_n = 0;
            repeat (4) begin
                sched_cycle(1'b1, 1'b0, hs);
                if (hs) rel_n++;
            end
            hs_n += rel_n;
            total_cnt++; if (rel_n !== 1) $display("FAIL lim_release%0d: got %0d want 1", r, rel_n); else pass_cnt++;
        end
        for (int c = 0; c < 200 && kd == 0; c++) begin
            sched_cycle(1'b1, 1'b1, hs);
            if (hs) hs_n++;
            if (kernel_done) kd++;
        end
        total_cnt++; if (hs_n !== 20) $display("FAIL lim_total: got %0d want 20", hs_n); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd20) $display("FAIL lim_issued_final: got %0d want 20", issued_cnt); else pass_cnt++;
        total_cnt++; if (kd !== 1) $display("FAIL lim_kdone: got %0d want 1", kd); else pass_cnt++;
        total_cnt++; if (err_sticky !== 2'b00) $display("FAIL lim_err: got %b want 00", err_sticky); else pass_cnt++;
    endtask

    task automatic test_zero_grid();
        do_start(32'd3, 32'd0, 32'd2, 12'd8, 12'd8, 6'd1, 32'h4000_0000);
        total_cnt++; if ({busy, cta_valid} !== 2'b10) $display("FAIL zero_load: got busy/valid %b want 10", {busy, cta_valid}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({kernel_done, busy, cta_valid} !== 3'b100) $display("FAIL zero_done: got kdone/busy/valid %b want 100", {kernel_done, busy, cta_valid}); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd0) $display("FAIL zero_issued: got %0d want 0", issued_cnt); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({kernel_done, cta_valid} !== 2'b00) $display("FAIL zero_after: got kdone/valid %b want 00", {kernel_done, cta_valid}); else pass_cnt++;
    endtask

    task automatic test_errors();
        logic hs;
        int hs_n = 0, kd = 0, pc_bad = 0;
        @(negedge clk); cta_done = 1'b1;
        @(negedge clk); cta_done = 1'b0;
        total_cnt++; if (err_sticky !== 2'b10) $display("FAIL err_spurious: got %b want 10", err_sticky); else pass_cnt++;
        do_start(32'd2, 32'd1, 32'd1, 12'd16, 12'd1, 6'd1, 32'hCAFE_0000);
        sched_cycle(1'b0, 1'b0, hs);
        start = 1'b1; cfg_nctaid_x = 32'd5; cfg_init_pc = 32'h0BAD_0000;
        for (int c = 0; c < 40 && kd == 0; c++) begin
            sched_cycle(1'b1, 1'b1, hs);
            start = 1'b0;
            if (hs) begin
                hs_n++;
                if (cta_pc !== 32'hCAFE_0000) pc_bad++;
            end
            if (kernel_done) kd++;
        end
        total_cnt++; if (err_sticky !== 2'b11) $display("FAIL err_both: got %b want 11", err_sticky); else pass_cnt++;
        total_cnt++; if (hs_n !== 2) $display("FAIL err_kernel_count: got %0d want 2", hs_n); else pass_cnt++;
        total_cnt++; if (pc_bad !== 0) $display("FAIL err_kernel_pc: got %0d bad descs want 0", pc_bad); else pass_cnt++;
        total_cnt++; if (issued_cnt !== 32'd2) $display("FAIL err_issued: got %0d want 2", issued_cnt); else pass_cnt++;
        total_cnt++; if (kd !== 1) $display("FAIL err_kdone: got %0d want 1", kd); else pass_cnt++;
    endtask

    task automatic test_abort();
        logic hs;
        int kd = 0, n = 0;
        do_start(32'd4, 32'd4, 32'd4, 12'd32, 12'd2, 6'd2, 32'h5000_0000);
        repeat (6) begin
            sched_cycle(1'b1, 1'b1, hs);
            if (kernel_done) kd++;
        end
        @(negedge clk); rst = 1'b1; cta_done = 1'b0;
        @(negedge clk);
        total_cnt++; if ({cta_valid, busy, kernel_done} !== 3'b000) $display("FAIL rst_abort_status: got %b want 000", {cta_valid, busy, kernel_done}); else pass_cnt++;
        total_cnt++; if ({issued_cnt, err_sticky} !== '0) $display("FAIL rst_abort_cnt: got issued %0d err %b want 0", issued_cnt, err_sticky); else pass_cnt++;
        total_cnt++; if ({cta_id_x, cta_id_y, cta_id_z, cta_ntid, cta_pc} !== '0)
            $display("FAIL rst_abort_payload: got %h want 0", {cta_id_x, cta_id_y, cta_id_z, cta_ntid, cta_pc}); else pass_cnt++;
        rst = 1'b0; model_if = 0;
        do_start(32'd4, 32'd4, 32'd4, 12'd32, 12'd2, 6'd2, 32'h5100_0000);
        for (int c = 0; c < 3; c++) begin
            sched_cycle(1'b1, 1'b1, hs);
            if (kernel_done) kd++;
            if (hs) begin
                total_cnt++; if ({cta_id_x, cta_id_y, cta_id_z, cta_pc} !== {n[31:0], 64'd0, 32'h5100_0000})
                    $display("FAIL restart_id%0d: got %h want x=%0d pc 51000000", n, {cta_id_x, cta_id_y, cta_id_z, cta_pc}, n); else pass_cnt++;
                n++;
            end
        end
        @(negedge clk); clear = 1'b1; cta_done = 1'b0;
        @(negedge clk); clear = 1'b0; model_if = 0;
        total_cnt++; if ({cta_valid, busy, kernel_done, issued_cnt} !== '0)
            $display("FAIL clear_abort: got valid/busy/kdone %b issued %0d want 0", {cta_valid, busy, kernel_done}, issued_cnt); else pass_cnt++;
        n = 0;
        do_start(32'hFFFF_FFFF, 32'd1, 32'd1, 12'd1, 12'd1, 6'd1, 32'h6000_0000);
        for (int c = 0; c < 4; c++) begin
            sched_cycle(1'b1, 1'b1, hs);
            if (kernel_done) kd++;
            if (hs) begin
                total_cnt++; if ({cta_id_x, cta_id_y, cta_id_z} !== {n[31:0], 64'd0})
                    $display("FAIL maxgrid_id%0d: got %h want x=%0d", n, {cta_id_x, cta_id_y, cta_id_z}, n); else pass_cnt++;
                n++;
            end
        end
        total_cnt++; if ({busy, cta_valid} !== 2'b11) $display("FAIL maxgrid_busy: got busy/valid %b want 11", {busy, cta_valid}); else pass_cnt++;
        @(negedge clk); clear = 1'b1; cta_done = 1'b0;
        @(negedge clk); clear = 1'b0; model_if = 0;
        total_cnt++; if (kd !== 0) $display("FAIL abort_no_kdone: got %0d pulses want 0", kd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_grid_2x2x1();
        test_backpressure();
        test_inflight_limit();
        test_zero_grid();
        test_errors();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run want finish before 500000");
        $fatal(1);
    end

endmodule
